// File: rtl/branch_predictor_if_pkg.sv
// Shared definitions for the fetch-stage branch predictor.
// Holds the 2-bit counter encodings, the reset and allocation values, and the
// PC index/tag slicing helpers.
package branch_predictor_if_pkg;

  localparam int unsigned CTR_BITS = 2;

  typedef logic [CTR_BITS-1:0] ctr_t;

  localparam ctr_t CTR_SNT   = 2'b00;
  localparam ctr_t CTR_WNT   = 2'b01;
  localparam ctr_t CTR_WT    = 2'b10;
  localparam ctr_t CTR_ST    = 2'b11;
  localparam ctr_t CTR_RESET = CTR_WNT;
  localparam ctr_t CTR_ALLOC = CTR_WT;

  // Table index: the word address bits just above the byte offset.
  function automatic logic [63:0] pc_index(input logic [63:0] pc, input int unsigned index_bits);
    return (pc >> 2) & ((64'd1 << index_bits) - 64'd1);
  endfunction

  // Tag: every PC bit above the index field.
  function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int unsigned index_bits);
    return pc >> (index_bits + 2);
  endfunction

endpackage

// File: rtl/branch_predictor_if_if.sv
// Lookup and training bus between the pipeline and the branch predictor.
//   pc_if, pred_jump, pred_target             : IF-stage lookup
//   upd_valid, upd_pc, upd_taken, upd_target,
//   upd_mispredict                            : EX-stage resolution/training
// master = pipeline side, slave = predictor side.
interface branch_predictor_if_if #(
  parameter int unsigned AddrBits = 32
) ();

  logic [AddrBits-1:0] pc_if;
  logic                pred_jump;
  logic [AddrBits-1:0] pred_target;

  logic                upd_valid;
  logic [AddrBits-1:0] upd_pc;
  logic                upd_taken;
  logic [AddrBits-1:0] upd_target;
  logic                upd_mispredict;

  modport master (
    output pc_if, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
    input  pred_jump, pred_target
  );

  modport slave (
    input  pc_if, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
    output pred_jump, pred_target
  );

endinterface

// File: rtl/branch_predictor_if_sat_counter2.sv
// Next-state logic for a 2-bit saturating branch counter.
//   ctr      : current counter value
//   taken    : resolved outcome
//   ctr_next : counter after one training step (saturates at 00 and 11)
module branch_predictor_if_sat_counter2
  import branch_predictor_if_pkg::*;
(
  input  ctr_t ctr,
  input  logic taken,
  output ctr_t ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor_if.sv
// Fetch-stage branch predictor: direct-mapped table of 2-bit counters + BTB.
//   Clock, nReset, ClockEnable : clock, async active-low reset, global enable
//   bus (slave)                : combinational IF lookup, EX training port
//   mispredict_cnt             : saturating mispredict count for debug display
module branch_predictor_if
  import branch_predictor_if_pkg::*;
#(
  parameter int unsigned AddrBits  = 32,
  parameter int unsigned IndexBits = 6,
  parameter int unsigned TagBits   = AddrBits - IndexBits - 2
) (
  input  logic                 Clock,
  input  logic                 nReset,
  input  logic                 ClockEnable,
  branch_predictor_if_if.slave bus,
  output logic [15:0]          mispredict_cnt
);

  localparam int unsigned Entries = 1 << IndexBits;

  typedef logic [IndexBits-1:0] idx_t;
  typedef logic [TagBits-1:0]   tag_t;

  logic                valid_q  [Entries];
  tag_t                tag_q    [Entries];
  logic [AddrBits-1:0] target_q [Entries];
  ctr_t                ctr_q    [Entries];

  idx_t lk_idx;
  tag_t lk_tag;
  logic lk_hit;
  idx_t up_idx;
  tag_t up_tag;
  logic up_hit;
  logic up_en;
  ctr_t up_ctr_next;

  // Address slicing for the lookup and training ports.
  always_comb begin
    lk_idx = IndexBits'(pc_index(64'(bus.pc_if), IndexBits));
    lk_tag = TagBits'(pc_tag(64'(bus.pc_if), IndexBits));
    up_idx = IndexBits'(pc_index(64'(bus.upd_pc), IndexBits));
    up_tag = TagBits'(pc_tag(64'(bus.upd_pc), IndexBits));
  end

  // Lookup reads the registered table directly, so an update on the same
  // edge is only seen the following cycle.
  always_comb begin
    lk_hit          = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    bus.pred_jump   = lk_hit && ctr_q[lk_idx][1];
    bus.pred_target = (lk_hit && ctr_q[lk_idx][1]) ? target_q[lk_idx] : '0;
  end

  always_comb begin
    up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_en  = ClockEnable && bus.upd_valid;
  end

  branch_predictor_if_sat_counter2 u_sat_counter2 (
    .ctr      (ctr_q[up_idx]),
    .taken    (bus.upd_taken),
    .ctr_next (up_ctr_next)
  );

  // Table training: hits train the counter, taken misses (re)allocate.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int unsigned i = 0; i < Entries; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_RESET;
      end
    end else if (up_en) begin
      if (up_hit) begin
        ctr_q[up_idx] <= up_ctr_next;
        if (bus.upd_taken) target_q[up_idx] <= bus.upd_target;
      end else if (bus.upd_taken) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= bus.upd_target;
        ctr_q[up_idx]    <= CTR_ALLOC;
      end
    end
  end

  // Saturating mispredict counter.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      mispredict_cnt <= '0;
    end else if (up_en && bus.upd_mispredict && (mispredict_cnt != 16'hFFFF)) begin
      mispredict_cnt <= mispredict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor_if.sv
// Scoreboard bench for branch_predictor_if: the driver issues one lookup and
// optional training update per cycle, pushes the reference model's expected
// lookup into a queue, and a monitor compares on the falling edge.
module tb_branch_predictor_if;

  logic        Clock = 1'b0;
  logic        nReset;
  logic        ClockEnable;
  logic [15:0] mispredict_cnt;

  always #5 Clock = ~Clock;

  branch_predictor_if_if #(.AddrBits(32)) bus ();

  branch_predictor_if dut (
    .Clock          (Clock),
    .nReset         (nReset),
    .ClockEnable    (ClockEnable),
    .bus            (bus),
    .mispredict_cnt (mispredict_cnt)
  );

  typedef struct {
    logic [31:0] pc;
    logic        jump;
    logic [31:0] target;
    logic [15:0] cnt;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: one record per index, counter kept as a plain integer.
  bit          m_valid  [64];
  int unsigned m_tag    [64];
  logic [31:0] m_target [64];
  int          m_ctr    [64];
  int          m_cnt;

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 0; m_target[i] = '0; m_ctr[i] = 1;
    end
    m_cnt = 0;
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc / 256;
  endfunction

  function automatic void model_lookup(input logic [31:0] pc, output logic j, output logic [31:0] t);
    int i;
    i = idx_of(pc);
    j = m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
    t = j ? m_target[i] : 32'h0;
  endfunction

  function automatic void model_update(input logic [31:0] pc, input bit taken,
                                       input logic [31:0] tgt, input bit mis);
    int i;
    i = idx_of(pc);
    if (m_valid[i] && m_tag[i] == tag_of(pc)) begin
      if (taken) begin
        m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        m_target[i] = tgt;
      end else begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
    end else if (taken) begin
      m_valid[i] = 1'b1; m_tag[i] = tag_of(pc); m_target[i] = tgt; m_ctr[i] = 2;
    end
    if (mis && m_cnt < 65535) m_cnt = m_cnt + 1;
  endfunction

  // One cycle: drive lookup + update just after the edge, record expectation.
  task automatic step(input logic [31:0] pc, input bit uv, input logic [31:0] upc,
                      input bit ut, input logic [31:0] utgt, input bit um,
                      input bit ce, input bit chk, input string name);
    exp_t e;
    @(posedge Clock);
    #1;
    bus.pc_if          = pc;
    bus.upd_valid      = uv;
    bus.upd_pc         = upc;
    bus.upd_taken      = ut;
    bus.upd_target     = utgt;
    bus.upd_mispredict = um;
    ClockEnable        = ce;
    if (chk) begin
      e.pc = pc;
      model_lookup(pc, e.jump, e.target);
      e.cnt  = 16'(m_cnt);
      e.name = name;
      sb_q.push_back(e);
    end
    if (ce && uv && nReset) model_update(upc, ut, utgt, um);
  endtask

  task automatic look(input logic [31:0] pc, input string name);
    step(pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, name);
  endtask

  // Monitor: compare the DUT's lookup outputs against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        vectors++;
        if (bus.pred_jump !== e.jump || bus.pred_target !== e.target || mispredict_cnt !== e.cnt) begin
          miscompares++;
          $display("FAIL %s pc=%08h: got jump=%0b target=%08h cnt=%04h, expected jump=%0b target=%08h cnt=%04h",
                   e.name, e.pc, bus.pred_jump, bus.pred_target, mispredict_cnt, e.jump, e.target, e.cnt);
        end
      end
    end
  end

  initial begin
    logic [31:0] rpc, rupc, rtgt;
    int          drain;

    nReset = 1'b0; ClockEnable = 1'b1;
    bus.pc_if = 32'h100; bus.upd_valid = 1'b0; bus.upd_pc = '0;
    bus.upd_taken = 1'b0; bus.upd_target = '0; bus.upd_mispredict = 1'b0;
    model_reset();

    look(32'h100, "reset_lookup_a");
    look(32'h3FC, "reset_lookup_b");
    @(negedge Clock); #2 nReset = 1'b1;

    // Allocation and target lookup.
    step(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b1, 1'b1, "alloc_miss");
    look(32'h100, "alloc_hit");
    look(32'h200, "other_pc_miss");
    // Train down to strongly not taken, then back up and saturate.
    step(32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, "nt_1");
    step(32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, "nt_2");
    look(32'h100, "after_nt_2");
    for (int i = 0; i < 4; i++) step(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b1, 1'b1, "taken_up");
    step(32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, "st_to_wt");
    look(32'h100, "still_taken");
    // Aliasing on index 0.
    step(32'h100, 1'b1, 32'h1100, 1'b1, 32'h40, 1'b0, 1'b1, 1'b1, "alias_alloc");
    look(32'h100, "alias_evicted");
    look(32'h1100, "alias_hit");
    // Same-cycle lookup/update, enabled and disabled.
    step(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b1, 1'b1, "realloc");
    step(32'h100, 1'b1, 32'h100, 1'b1, 32'h300, 1'b0, 1'b1, 1'b1, "same_cycle_old");
    look(32'h100, "same_cycle_new");
    step(32'h100, 1'b1, 32'h100, 1'b1, 32'h500, 1'b1, 1'b0, 1'b1, "ce_low_old");
    step(32'h2100, 1'b1, 32'h2100, 1'b1, 32'h600, 1'b1, 1'b0, 1'b1, "ce_low_alloc");
    look(32'h100, "ce_low_unchanged");
    look(32'h2100, "ce_low_no_alloc");
    // Three mispredicts, then asynchronous reset mid-cycle.
    for (int i = 0; i < 3; i++) step(32'h4000, 1'b1, 32'h4000, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, "mis_count");
    look(32'h100, "mis_count_3");
    @(posedge Clock); #3;
    bus.upd_valid = 1'b1; bus.upd_pc = 32'h100; bus.upd_taken = 1'b1;
    bus.upd_target = 32'h700; bus.upd_mispredict = 1'b1; bus.pc_if = 32'h100;
    nReset = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (mispredict_cnt !== 16'h0 || bus.pred_jump !== 1'b0 || bus.pred_target !== 32'h0) begin
      miscompares++;
      $display("FAIL async_reset: got jump=%0b target=%08h cnt=%04h, expected 0/00000000/0000",
               bus.pred_jump, bus.pred_target, mispredict_cnt);
    end
    look(32'h100, "in_reset_0100");
    look(32'h1100, "in_reset_1100");
    @(negedge Clock); #2 nReset = 1'b1;
    step(32'h100, 1'b1, 32'h100, 1'b1, 32'h800, 1'b1, 1'b1, 1'b1, "post_reset_miss");
    look(32'h100, "post_reset_first_update");

    // Randomized traffic over a small PC pool to force hits and aliases.
    for (int n = 0; n < 600; n++) begin
      rpc  = ($urandom_range(0, 2) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      rupc = ($urandom_range(0, 2) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      rtgt = $urandom();
      step(rpc, ($urandom_range(0, 3) != 0), rupc, 1'($urandom_range(0, 1)), rtgt,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0), 1'b1, "random");
    end

    // Mispredict counter saturation.
    while (m_cnt < 65534)
      step(32'h100, 1'b1, 32'h4000, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, "fill");
    step(32'h100, 1'b1, 32'h4000, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, "cnt_fffe");
    step(32'h100, 1'b1, 32'h4000, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, "cnt_ffff");
    look(32'h100, "cnt_saturated");

    drain = 0;
    while (sb_q.size() > 0 && drain < 10) begin
      @(negedge Clock); #1;
      drain++;
    end
    if (sb_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
